regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1, cycles spent in READ before sampling rf_data_out (range 1-3).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports op_valid in 1, op_kind in 2 (00 read, 01 write, 10 rmw, 11 treated as read), op_addr7 in 7 (instruction file field), op_dest_f in 1 (rmw writeback to file), op_wdata in 8.
REQ-005 SHALL have ports status_rp in 2, status_irp in 1, fsr_val in 8: bank and indirect-address sources.
REQ-006 SHALL have ports alu_result in 8 (combinational from rd_data), ready out 1, done out 1, rd_data out 8.
REQ-007 SHALL have ports rf_addr out 9, rf_wr_en out 1, rf_data_in out 8, rf_data_out in 8 (register-file bus initiator side).

Function
REQ-008 SHALL form the address as {status_irp, fsr_val} when op_addr7==0 (INDF), else {status_rp, op_addr7}, and latch it on op acceptance.
REQ-009 SHALL accept an op only when op_valid && ready; op_valid while not ready is ignored, with no queuing.
REQ-010 SHALL implement states IDLE, ADDR, READ, WRITE; ready is high only in IDLE.
REQ-011 Transitions: IDLE->ADDR on accept.
REQ-012 Transitions: ADDR->READ for read/rmw, and ADDR->WRITE for write.
REQ-013 Transitions: READ->WRITE after READ_WAIT cycles for rmw with op_dest_f=1; otherwise READ->IDLE.
REQ-014 Transitions: WRITE->IDLE after one cycle.
REQ-015 SHALL hold rf_addr stable at the latched address from ADDR through the final state; rf_addr SHALL be 0 in IDLE.
REQ-016 SHALL assert rf_wr_en only in WRITE, for exactly one cycle, with rf_data_in = op_wdata (write) or latched alu_result (rmw).
REQ-017 SHALL capture rf_data_out into rd_data at the last READ cycle; rd_data holds until the next capture.
REQ-018 SHALL sample alu_result into a register at the last READ cycle for rmw.
REQ-019 SHALL pulse done high for one cycle in the cycle after the final state, coincident with the return to IDLE.
REQ-020 Latency with READ_WAIT=1, accept at edge k: read done at k+3; write done at k+2 with rf_wr_en at k+1; rmw/dest_f done at k+4.
REQ-021 Back-to-back: a new op SHALL be acceptable in the same cycle done is high.
REQ-022 STATUS/FSR changes after acceptance SHALL NOT affect the latched address.

Reset
REQ-023 rst SHALL force state IDLE, rd_data 0, the alu latch 0 and done 0 at the next edge; rf_addr, rf_wr_en and rf_data_in SHALL all be 0.
REQ-024 rst asserted mid-operation SHALL abort the op with no write issued after the reset edge and no done pulse.

Configuration
REQ-025 Macro RFAC_INDF_NULL_EN: when defined, an indirect access whose latched address[6:0]==0 SHALL return rd_data 0x00 and suppress rf_wr_en, while the WRITE state still occurs.
REQ-026 Without RFAC_INDF_NULL_EN, such an access SHALL pass to the register file unmodified.

Structure
REQ-027 State encodings, op_kind codes and the INDF address constant SHALL live in the shared memory_map.vh definitions.
REQ-028 Address formation SHALL be a combinational sub-module rfac_addr_gen; everything else SHALL be in the top module.

Verification
REQ-029 Direct read: rp=01, op_addr7=0x20, RAM[0xA0]=0x5A -> rd_data=0x5A, done at k+3, rf_wr_en never high.
REQ-030 Indirect write: op_addr7=0, irp=1, fsr=0x30, wdata=0xC3 -> one-cycle rf_wr_en with rf_addr=0x130 and rf_data_in=0xC3.
REQ-031 RMW incf: mem 0x7F, alu_result=rd_data+1, dest_f=1 -> write of 0x80 to the same address; with dest_f=0 -> no write and done at k+3.
REQ-032 Reset mid-op: rst in READ of an rmw -> state IDLE, no rf_wr_en, no done, rd_data=0.
REQ-033 Busy ignore plus back-to-back: op_valid held during an op -> second op accepted only at the done cycle; FSR change mid-op leaves rf_addr unchanged.
REQ-034 INDF null (macro on): fsr=0x80, irp=0, write 0x11 -> rf_wr_en stays low; read -> rd_data=0x00; macro off -> access reaches address 0x080.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared encodings for regfile_access_ctrl: FSM states, op_kind codes and the INDF address.
// op_kind codes not listed here (00 and 11) are handled as reads.
package regfile_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_RMW    = 2'b10;
    localparam logic [6:0] INDF_ADDR = 7'h00;

endpackage

// File: rtl/rfac_addr_gen.sv
// Register-file address formation: INDF (op_addr7 == 0) goes through {IRP, FSR},
// everything else is banked as {RP, op_addr7}.
module rfac_addr_gen
    import regfile_access_ctrl_pkg::*;
(
    input  logic [6:0] i_addr7,
    input  logic [1:0] i_status_rp,
    input  logic       i_status_irp,
    input  logic [7:0] i_fsr_val,
    output logic [8:0] o_addr
);

    assign o_addr = (i_addr7 == INDF_ADDR) ? {i_status_irp, i_fsr_val}
                                           : {i_status_rp, i_addr7};

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer for read / write / read-modify-write ops.
// Optional feature macro RFAC_INDF_NULL_EN: indirect accesses to address[6:0]==0 read 0, drop the write.
//
// state | meaning
// IDLE  | ready, waiting for op_valid
// ADDR  | latched address driven onto rf_addr
// READ  | READ_WAIT wait cycles, then one sample cycle
// WRITE | single-cycle rf_wr_en strobe
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int unsigned READ_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [1:0] op_kind,
    input  logic [6:0] op_addr7,
    input  logic       op_dest_f,
    input  logic [7:0] op_wdata,
    input  logic [1:0] status_rp,
    input  logic       status_irp,
    input  logic [7:0] fsr_val,
    input  logic [7:0] alu_result,
    output logic       ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic [8:0] rf_addr,
    output logic       rf_wr_en,
    output logic [7:0] rf_data_in,
    input  logic [7:0] rf_data_out
);

    localparam logic [1:0] WAIT_LOAD = 2'(READ_WAIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [8:0] r_addr;
    logic       r_is_write;
    logic       r_is_rmw;
    logic       r_dest_f;
    logic [7:0] r_wdata;
    logic [7:0] r_rd_data;
    logic [7:0] r_alu;
    logic [1:0] r_cnt;
    logic       r_done;

    logic [8:0] w_addr;
    logic       w_accept;
    logic       w_last_read;
    logic       w_null;
    logic [7:0] w_rd_next;

    rfac_addr_gen u_addr_gen (
        .i_addr7      (op_addr7),
        .i_status_rp  (status_rp),
        .i_status_irp (status_irp),
        .i_fsr_val    (fsr_val),
        .o_addr       (w_addr)
    );

    assign w_accept    = op_valid && ready;
    assign w_last_read = (r_state == ST_READ) && (r_cnt == 2'd0);

`ifdef RFAC_INDF_NULL_EN
    logic r_indf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_indf <= 1'b0;
        end else if (w_accept) begin
            r_indf <= (op_addr7 == INDF_ADDR);
        end
    end

    assign w_null = r_indf && (r_addr[6:0] == INDF_ADDR);
`else
    assign w_null = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_ADDR;
            ST_ADDR:  w_state_nxt = r_is_write ? ST_WRITE : ST_READ;
            ST_READ:  if (w_last_read) w_state_nxt = (r_is_rmw && r_dest_f) ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_is_rmw   <= 1'b0;
            r_dest_f   <= 1'b0;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_alu      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
        end else begin
            // done lands in the first IDLE cycle after the op's final state
            r_done <= (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_addr     <= w_addr;
                r_is_write <= (op_kind == OP_WRITE);
                r_is_rmw   <= (op_kind == OP_RMW);
                r_dest_f   <= op_dest_f;
                r_wdata    <= op_wdata;
            end
            if (r_state == ST_ADDR) begin
                r_cnt <= WAIT_LOAD;
            end else if ((r_state == ST_READ) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_last_read) begin
                r_rd_data <= w_rd_next;
                if (r_is_rmw) r_alu <= alu_result;
            end
        end
    end

    // The sample cycle forwards rf_data_out so the external ALU sees fresh data at the same edge.
    assign w_rd_next  = w_null ? 8'h00 : rf_data_out;
    assign rd_data    = w_last_read ? w_rd_next : r_rd_data;
    assign ready      = (r_state == ST_IDLE);
    assign done       = r_done;
    assign rf_addr    = ready ? 9'd0 : r_addr;
    assign rf_wr_en   = (r_state == ST_WRITE) && !w_null;
    assign rf_data_in = (r_state == ST_WRITE) ? (r_is_rmw ? r_alu : r_wdata) : 8'h00;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl: stimulus pushes expected writes / done events,
// a negedge monitor pops and compares them. Honors RFAC_INDF_NULL_EN when defined.
module tb_regfile_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [1:0] op_kind = 2'b00;
    logic [6:0] op_addr7 = 7'h00;
    logic       op_dest_f = 1'b0;
    logic [7:0] op_wdata = 8'h00;
    logic [1:0] status_rp = 2'b00;
    logic       status_irp = 1'b0;
    logic [7:0] fsr_val = 8'h00;
    logic [7:0] alu_result;
    logic       ready, done, rf_wr_en;
    logic [7:0] rd_data, rf_data_in, rf_data_out;
    logic [8:0] rf_addr;

    logic [7:0] mem [0:511];
    logic       bd_we = 1'b0;
    logic [8:0] bd_addr = 9'd0;
    logic [7:0] bd_data = 8'h00;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [8:0] exp_addr = 9'd0;

    typedef struct {logic chk_rd; logic [7:0] rd; int cyc; string name;} done_exp_t;
    typedef struct {logic [8:0] addr; logic [7:0] data; int cyc; string name;} wr_exp_t;
    done_exp_t dq[$];
    wr_exp_t   wq[$];

    regfile_access_ctrl #(.READ_WAIT(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_kind(op_kind), .op_addr7(op_addr7),
        .op_dest_f(op_dest_f), .op_wdata(op_wdata), .status_rp(status_rp),
        .status_irp(status_irp), .fsr_val(fsr_val), .alu_result(alu_result),
        .ready(ready), .done(done), .rd_data(rd_data), .rf_addr(rf_addr),
        .rf_wr_en(rf_wr_en), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register file and incf ALU models
    assign rf_data_out = mem[rf_addr];
    assign alu_result  = rd_data + 8'd1;
    always @(posedge clk) begin
        if (rf_wr_en) mem[rf_addr] <= rf_data_in;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rf_addr", {23'd0, rf_addr}, {23'd0, (ready ? 9'd0 : exp_addr)});
            if (rf_wr_en) begin
                wr_exp_t w;
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h cyc=%0d required none",
                             rf_addr, rf_data_in, cyc);
                end else begin
                    w = wq.pop_front();
                    chk({w.name, "_wr_addr"}, {23'd0, rf_addr}, {23'd0, w.addr});
                    chk({w.name, "_wr_data"}, {24'd0, rf_data_in}, {24'd0, w.data});
                    chk({w.name, "_wr_cyc"}, cyc, w.cyc);
                end
            end
            if (done) begin
                done_exp_t d;
                if (dq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual cyc=%0d required none", cyc);
                end else begin
                    d = dq.pop_front();
                    chk({d.name, "_done_cyc"}, cyc, d.cyc);
                    if (d.chk_rd) chk({d.name, "_rd_data"}, {24'd0, rd_data}, {24'd0, d.rd});
                end
            end
        end
    end

    task automatic preset(input logic [8:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [6:0] a7, input logic df,
                         input logic [7:0] wd, input logic [1:0] rp, input logic irp,
                         input logic [7:0] fsr, input logic [8:0] ea, output int k);
        int n = 0;
        while (!ready && n < 50) begin @(negedge clk); n++; end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL issue_ready_timeout actual ready=0 required 1");
        end
        op_kind = kind; op_addr7 = a7; op_dest_f = df; op_wdata = wd;
        status_rp = rp; status_irp = irp; fsr_val = fsr; op_valid = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        exp_addr = ea;
        op_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((dq.size() != 0 || wq.size() != 0 || !ready) && n < 30) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (dq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual pending=%0d required 0", name, dq.size() + wq.size());
            dq.delete(); wq.delete();
        end
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", {31'd0, ready}, 1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        chk("rst_rf_addr", {23'd0, rf_addr}, 0);
        chk("rst_rf_wr_en", {31'd0, rf_wr_en}, 0);
        chk("rst_rf_data_in", {24'd0, rf_data_in}, 0);
        mon_en = 1'b1;

        // direct banked read
        preset(9'h0A0, 8'h5A);
        issue(2'b00, 7'h20, 1'b0, 8'h00, 2'b01, 1'b0, 8'h00, 9'h0A0, k);
        dq.push_back('{1'b1, 8'h5A, k + 3, "rd_direct"});
        drain("rd_direct");

        // indirect write
        issue(2'b01, 7'h00, 1'b0, 8'hC3, 2'b00, 1'b1, 8'h30, 9'h130, k);
        wq.push_back('{9'h130, 8'hC3, k + 1, "wr_indirect"});
        dq.push_back('{1'b0, 8'h00, k + 2, "wr_indirect"});
        drain("wr_indirect");
        chk("wr_indirect_mem", {24'd0, mem[9'h130]}, 32'hC3);

        // rmw incf with writeback
        preset(9'h025, 8'h7F);
        issue(2'b10, 7'h25, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 9'h025, k);
        wq.push_back('{9'h025, 8'h80, k + 3, "rmw_f1"});
        dq.push_back('{1'b1, 8'h7F, k + 4, "rmw_f1"});
        drain("rmw_f1");
        chk("rmw_f1_mem", {24'd0, mem[9'h025]}, 32'h80);

        // rmw without writeback
        preset(9'h026, 8'h7F);
        issue(2'b10, 7'h26, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 9'h026, k);
        dq.push_back('{1'b1, 8'h7F, k + 3, "rmw_f0"});
        drain("rmw_f0");
        chk("rmw_f0_mem", {24'd0, mem[9'h026]}, 32'h7F);

        // spare op_kind code behaves as read
        preset(9'h105, 8'h3C);
        issue(2'b11, 7'h05, 1'b0, 8'h00, 2'b10, 1'b0, 8'h00, 9'h105, k);
        dq.push_back('{1'b1, 8'h3C, k + 3, "rd_kind11"});
        drain("rd_kind11");

        // reset during READ of an rmw: no write, no done
        preset(9'h027, 8'h10);
        issue(2'b10, 7'h27, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 9'h027, k);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", {31'd0, ready}, 1);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_rd_data", {24'd0, rd_data}, 0);
        repeat (5) @(posedge clk); #1;
        chk("midrst_mem", {24'd0, mem[9'h027]}, 32'h10);

        // busy ignore, back-to-back at done, FSR change mid-op
        preset(9'h044, 8'h77);
        issue(2'b00, 7'h00, 1'b0, 8'h00, 2'b00, 1'b0, 8'h44, 9'h044, k);
        op_kind = 2'b01; op_addr7 = 7'h10; op_wdata = 8'hAB; status_rp = 2'b11;
        fsr_val = 8'h99; op_valid = 1'b1;
        dq.push_back('{1'b1, 8'h77, k + 3, "b2b_rd"});
        wq.push_back('{9'h190, 8'hAB, k + 5, "b2b_wr"});
        dq.push_back('{1'b1, 8'h77, k + 6, "b2b_wr"});
        repeat (4) @(posedge clk); #1;
        exp_addr = 9'h190;
        op_valid = 1'b0;
        drain("b2b");
        chk("b2b_mem", {24'd0, mem[9'h190]}, 32'hAB);

        // indirect access to a null (address[6:0]==0) location
        preset(9'h080, 8'h5E);
        issue(2'b01, 7'h00, 1'b0, 8'h11, 2'b00, 1'b0, 8'h80, 9'h080, k);
`ifdef RFAC_INDF_NULL_EN
        dq.push_back('{1'b0, 8'h00, k + 2, "null_wr"});
        drain("null_wr");
        chk("null_wr_mem", {24'd0, mem[9'h080]}, 32'h5E);
        issue(2'b00, 7'h00, 1'b0, 8'h00, 2'b00, 1'b0, 8'h80, 9'h080, k);
        dq.push_back('{1'b1, 8'h00, k + 3, "null_rd"});
`else
        wq.push_back('{9'h080, 8'h11, k + 1, "null_wr"});
        dq.push_back('{1'b0, 8'h00, k + 2, "null_wr"});
        drain("null_wr");
        chk("null_wr_mem", {24'd0, mem[9'h080]}, 32'h11);
        issue(2'b00, 7'h00, 1'b0, 8'h00, 2'b00, 1'b0, 8'h80, 9'h080, k);
        dq.push_back('{1'b1, 8'h11, k + 3, "null_rd"});
`endif
        drain("null_rd");

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
